// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding, defaults and a clog2 helper.

package rr_arb_pkg;

    localparam int unsigned REQ_W_DEF    = 8;
    localparam int unsigned HOLD_MAX_DEF = 16;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < v) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit in vec, plus an any-set flag.

module rr_prio_enc #(
    parameter int unsigned REQ_W = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [REQ_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        idx = '0;
        // Scan from the top so the lowest set bit is the last assignment.
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        vld = |vec;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant that is held until the holder releases.
// Define RR_ARBITER_TIMEOUT_EN to bound tenure to HOLD_MAX cycles when others are waiting.

import rr_arb_pkg::*;

module rr_arbiter #(
    parameter int unsigned REQ_W    = REQ_W_DEF,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_W-1:0] req,
    output logic [REQ_W-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    if (IDX_W != clog2(REQ_W)) begin : g_bad_idx_w
        $error("rr_arbiter: IDX_W must equal clog2(REQ_W)");
    end
    if (REQ_W < 2 || HOLD_MAX < 1) begin : g_bad_params
        $error("rr_arbiter: REQ_W must be >= 2 and HOLD_MAX >= 1");
    end

    state_e           state_q, state_d;
    logic [REQ_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;

    logic             holder_req;
    logic             timeout;
    logic [IDX_W-1:0] start;
    logic [REQ_W-1:0] arb_req;
    logic [REQ_W-1:0] rot;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_vld;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] win_idx;
    logic [REQ_W-1:0] win_oh;

    assign holder_req = req[idx_q];
    assign start      = (last_q == IDX_W'(REQ_W - 1)) ? '0 : last_q + 1'b1;
    // On a forced release the holder must not win its own re-arbitration.
    assign arb_req    = req & ~(timeout ? grant_q : '0);
    assign rot        = (arb_req >> start) | (arb_req << (REQ_W - int'(start)));

    rr_prio_enc #(
        .REQ_W (REQ_W),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec (rot),
        .idx (enc_idx),
        .vld (enc_vld)
    );

    assign sum     = {1'b0, enc_idx} + {1'b0, start};
    assign win_idx = (sum >= (IDX_W + 1)'(REQ_W)) ? IDX_W'(sum - (IDX_W + 1)'(REQ_W))
                                                   : IDX_W'(sum);
    assign win_oh  = {{(REQ_W - 1){1'b0}}, 1'b1} << win_idx;

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == StBusy) && holder_req && (cnt_q == CNT_W'(HOLD_MAX - 1));

    // Counts only uninterrupted holds; any hand-off or forced restart goes back to zero.
    always_comb begin
        cnt_d = '0;
        if (state_q == StBusy && state_d == StBusy && grant_d == grant_q && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (enc_vld) begin
                    state_d = StBusy;
                    grant_d = win_oh;
                    idx_d   = win_idx;
                    last_d  = win_idx;
                end
            end
            StBusy: begin
                if (holder_req && !timeout) begin
                    state_d = StBusy;
                end else if (enc_vld) begin
                    grant_d = win_oh;
                    idx_d   = win_idx;
                    last_d  = win_idx;
                end else if (!timeout) begin
                    state_d = StIdle;
                    grant_d = '0;
                    idx_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IDX_W'(REQ_W - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = idx_q;
    assign grant_vld = (state_q == StBusy);

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: directed scenarios plus random traffic against a reference model.

module tb_rr_arbiter;

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned HM = 4;
`ifdef RR_ARBITER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_vld;

    always #5 clk = ~clk;

    rr_arbiter #(
        .REQ_W    (N),
        .IDX_W    (IW),
        .HOLD_MAX (HM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    typedef struct {
        logic [N-1:0]  g;
        logic [IW-1:0] i;
        logic          v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: current holder (-1 = none), last winner, cycles held.
    int m_holder;
    int m_last;
    int m_cnt;

    task automatic chk(input string name, input logic [N+IW:0] act, input logic [N+IW:0] expv);
        checks++;
        if (act === expv) begin
            passes++;
        end else begin
            $display("FAIL %s: got {grant,idx,vld}=%h, expected %h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_holder = -1;
        m_last   = N - 1;
        m_cnt    = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        int   win;
        bit   tmo;
        bit   holding;
        exp_t e;
        win     = -1;
        tmo     = 1'b0;
        holding = (m_holder >= 0) && r[m_holder];
        if (holding) begin
            if (TMO_EN && m_cnt == HM - 1) tmo = 1'b1;
            else m_cnt++;
        end
        if (!holding || tmo) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (r[c] && !(tmo && c == m_holder)) begin
                    win = c;
                    break;
                end
            end
            if (win >= 0) begin
                m_holder = win;
                m_last   = win;
                m_cnt    = 0;
            end else if (tmo) begin
                m_cnt = 0;
            end else begin
                m_holder = -1;
                m_cnt    = 0;
            end
        end
        e.v = (m_holder >= 0);
        e.g = e.v ? (N'(1) << m_holder) : '0;
        e.i = e.v ? IW'(m_holder) : '0;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] r);
        @(negedge clk);
        req = r;
        model_step(r);
        @(posedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk($sformatf("grant@%0t", $time), {grant, grant_idx, grant_vld}, {e.g, e.i, e.v});
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        int           wait_cyc;
        rst = 1'b1;
        req = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_state", {grant, grant_idx, grant_vld}, '0);

        repeat (5) step(8'h00);

        step(8'h81);
        step(8'h80);

        for (int t = 0; t < 9; t++) begin
            step(8'hFF);
            r = 8'hFF;
            r[m_holder] = 1'b0;
            step(r);
        end

        step(8'h00);
        step(8'h00);
        step(8'h08);
        step(8'h0C);
        step(8'h0E);
        step(8'h06);

        step(8'h30);
        step(8'h30);
        #2;
        req = '0;
        rst = 1'b1;
        #1;
        chk("async_reset", {grant, grant_idx, grant_vld}, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(8'h30);
        step(8'h30);

        for (int t = 0; t < 1500; t++) begin
            r = N'($urandom);
            if (m_holder >= 0) r[m_holder] = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0) r = '0;
            step(r);
        end
        step(8'h00);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expected grants left, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
